// File: rtl/axinwarbiter.sv
// axinwarbiter: weighted round-robin packet arbiter for AXIN streams, with one registered output stage.
// Define AXINWARB_MAXLEN_EN to enable the packet length watchdog (DRAIN state, o_lenerr).
module axinwarbiter #(
   parameter int NIN     = 4,
   parameter int DW      = 64,
   parameter int WBITS   = $clog2(DW/8),
   parameter int WEIGHTW = 4,
   parameter int MAXLEN  = 200
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [NIN*WEIGHTW-1:0] i_weights,
   input  logic [NIN-1:0]         S_VALID,
   output logic [NIN-1:0]         S_READY,
   input  logic [NIN*DW-1:0]      S_DATA,
   input  logic [NIN*WBITS-1:0]   S_BYTES,
   input  logic [NIN-1:0]         S_LAST,
   input  logic [NIN-1:0]         S_ABORT,
   output logic                   M_VALID,
   input  logic                   M_READY,
   output logic [DW-1:0]          M_DATA,
   output logic [WBITS-1:0]       M_BYTES,
   output logic                   M_LAST,
   output logic                   M_ABORT,
   output logic [NIN-1:0]         o_grant,
   output logic [NIN-1:0]         o_lenerr
);
   localparam int PW = $clog2(NIN);
`ifdef AXINWARB_MAXLEN_EN
   localparam int CW = $clog2(MAXLEN+2);
   typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;
`else
   localparam int CW = 1;
   typedef enum logic [0:0] {IDLE, PASS} state_t;
`endif

   state_t               state_q, state_d;
   logic [NIN-1:0]       grant_q, grant_d;
   logic [PW-1:0]        port_q, port_d;
   logic [PW-1:0]        last_q, last_d;
   logic [WEIGHTW-1:0]   credit_q, credit_d;
   logic [CW-1:0]        wcount_q, wcount_d;
   logic                 mvalid_q, mvalid_d;
   logic [DW-1:0]        mdata_q, mdata_d;
   logic [WBITS-1:0]     mbytes_q, mbytes_d;
   logic                 mlast_q, mlast_d;
   logic                 mabort_q, mabort_d;

   logic                 sel_valid, sel_last, out_free, found, done, emit_abort, fwd;
   logic [DW-1:0]        sel_data;
   logic [WBITS-1:0]     sel_bytes;
   logic [PW-1:0]        next_port;

   function automatic logic [NIN-1:0] onehot(input logic [PW-1:0] p);
      onehot    = '0;
      onehot[p] = 1'b1;
   endfunction

   // Saturating beat counter; without the watchdog it only flags "not first beat".
   function automatic logic [CW-1:0] wcount_inc(input logic [CW-1:0] w);
`ifdef AXINWARB_MAXLEN_EN
      return (w == CW'(MAXLEN+1)) ? w : w + 1'b1;
`else
      return w | CW'(1);
`endif
   endfunction

   assign sel_valid = S_VALID[port_q];
   assign sel_last  = S_LAST[port_q];
   assign sel_data  = S_DATA[port_q*DW +: DW];
   assign sel_bytes = S_BYTES[port_q*WBITS +: WBITS];
   assign out_free  = !mvalid_q || M_READY;

   // Round-robin search upward from last_port+1; last_port itself is checked last.
   always_comb begin
      int c;
      c         = 0;
      found     = 1'b0;
      next_port = last_q;
      for (int i = 1; i <= NIN; i++) begin
         c = int'(last_q) + i;
         if (c >= NIN) c = c - NIN;
         if (!found && S_VALID[PW'(c)]) begin
            found     = 1'b1;
            next_port = PW'(c);
         end
      end
   end

`ifdef AXINWARB_MAXLEN_EN
   logic [NIN-1:0] lenerr_q, lenerr_d;
`endif

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      port_d     = port_q;
      last_d     = last_q;
      credit_d   = credit_q;
      wcount_d   = wcount_q;
      mvalid_d   = mvalid_q && !M_READY;
      mdata_d    = mdata_q;
      mbytes_d   = mbytes_q;
      mlast_d    = mlast_q;
      mabort_d   = mabort_q;
      S_READY    = '0;
      done       = 1'b0;
      emit_abort = 1'b0;
      fwd        = 1'b0;
`ifdef AXINWARB_MAXLEN_EN
      lenerr_d   = '0;
`endif
      case (state_q)
         IDLE: begin
            if (S_VALID[last_q] && credit_q != '0) begin
               grant_d  = onehot(last_q);
               port_d   = last_q;
               credit_d = credit_q - 1'b1;
               wcount_d = '0;
               state_d  = PASS;
            end else if (found) begin
               grant_d  = onehot(next_port);
               port_d   = next_port;
               credit_d = i_weights[next_port*WEIGHTW +: WEIGHTW];
               wcount_d = '0;
               state_d  = PASS;
            end
         end
         PASS: begin
            S_READY = grant_q & {NIN{out_free}};
            if (S_ABORT[port_q]) begin
               // An abort before any forwarded beat leaves nothing downstream to cancel.
               if (wcount_q == '0) begin
                  done = 1'b1;
               end else if (out_free) begin
                  emit_abort = 1'b1;
                  done       = 1'b1;
               end
            end else if (sel_valid && out_free) begin
`ifdef AXINWARB_MAXLEN_EN
               if (wcount_q == CW'(MAXLEN)) begin
                  emit_abort       = 1'b1;
                  lenerr_d[port_q] = 1'b1;
                  if (sel_last) done = 1'b1;
                  else          state_d = DRAIN;
               end else begin
                  fwd  = 1'b1;
                  done = sel_last;
               end
`else
               fwd  = 1'b1;
               done = sel_last;
`endif
            end
         end
`ifdef AXINWARB_MAXLEN_EN
         DRAIN: begin
            S_READY = grant_q;
            done    = S_ABORT[port_q] || (sel_valid && sel_last);
         end
`endif
         default: state_d = IDLE;
      endcase

      if (fwd) begin
         mvalid_d = 1'b1;
         mdata_d  = sel_data;
         mbytes_d = sel_bytes;
         mlast_d  = sel_last;
         mabort_d = 1'b0;
         wcount_d = wcount_inc(wcount_q);
      end
      if (emit_abort) begin
         mvalid_d = 1'b1;
         mdata_d  = '0;
         mbytes_d = '0;
         mlast_d  = 1'b0;
         mabort_d = 1'b1;
      end
      if (done) begin
         state_d = IDLE;
         grant_d = '0;
         last_d  = port_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         port_q   <= '0;
         last_q   <= PW'(NIN-1);
         credit_q <= '0;
         wcount_q <= '0;
         mvalid_q <= 1'b0;
         mdata_q  <= '0;
         mbytes_q <= '0;
         mlast_q  <= 1'b0;
         mabort_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         port_q   <= port_d;
         last_q   <= last_d;
         credit_q <= credit_d;
         wcount_q <= wcount_d;
         mvalid_q <= mvalid_d;
         mdata_q  <= mdata_d;
         mbytes_q <= mbytes_d;
         mlast_q  <= mlast_d;
         mabort_q <= mabort_d;
      end
   end

`ifdef AXINWARB_MAXLEN_EN
   always_ff @(posedge i_clk) begin
      if (i_reset) lenerr_q <= '0;
      else         lenerr_q <= lenerr_d;
   end
   assign o_lenerr = lenerr_q;
`else
   assign o_lenerr = '0;
`endif

   assign M_VALID = mvalid_q;
   assign M_DATA  = mdata_q;
   assign M_BYTES = mbytes_q;
   assign M_LAST  = mlast_q;
   assign M_ABORT = mabort_q;
   assign o_grant = grant_q;
endmodule

// File: tb/tb_axinwarbiter.sv
// Directed bench for axinwarbiter: queued per-port sources, output beat log, hand-listed expectations.
module tb_axinwarbiter;
   localparam int NIN = 4, DW = 64, WBITS = 3, WEIGHTW = 4, MAXLEN = 4;

   typedef struct packed {
      logic             abort;
      logic             last;
      logic [WBITS-1:0] bytes;
      logic [DW-1:0]    data;
   } beat_t;

   logic                   i_clk = 1'b0;
   logic                   i_reset;
   logic [NIN*WEIGHTW-1:0] i_weights;
   logic [NIN-1:0]         S_VALID, S_READY, S_LAST, S_ABORT;
   logic [NIN*DW-1:0]      S_DATA;
   logic [NIN*WBITS-1:0]   S_BYTES;
   logic                   M_VALID, M_READY, M_LAST, M_ABORT;
   logic [DW-1:0]          M_DATA;
   logic [WBITS-1:0]       M_BYTES;
   logic [NIN-1:0]         o_grant, o_lenerr;

   always #5 i_clk = ~i_clk;

   axinwarbiter #(.NIN(NIN), .DW(DW), .WBITS(WBITS), .WEIGHTW(WEIGHTW), .MAXLEN(MAXLEN)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_weights(i_weights),
      .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA), .S_BYTES(S_BYTES),
      .S_LAST(S_LAST), .S_ABORT(S_ABORT),
      .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA), .M_BYTES(M_BYTES),
      .M_LAST(M_LAST), .M_ABORT(M_ABORT), .o_grant(o_grant), .o_lenerr(o_lenerr)
   );

   beat_t          srcq [NIN][$];
   beat_t          outq [$];
   int             outcyc [$];
   int             cyc = 0;
   int             checks = 0;
   int             failures = 0;
   logic [NIN-1:0] fire = '0;
   bit             toggle_mode = 1'b0;
   bit             chk_stable = 1'b0;
   bit             prev_stall = 1'b0;
   logic [DW-1:0]  prev_data = '0;
   int             lenerr_cnt = 0;
   logic [NIN-1:0] lenerr_val = '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic beat_t mk(input int port, input int pkt, input int b, input bit last);
      beat_t t;
      t.abort = 1'b0;
      t.last  = last;
      t.bytes = WBITS'(b + 1);
      t.data  = DW'(port * 65536 + pkt * 256 + b);
      return t;
   endfunction

   task automatic push_pkt(input int port, input int pkt, input int n);
      for (int b = 0; b < n; b++) srcq[port].push_back(mk(port, pkt, b, b == n - 1));
   endtask

   task automatic push_abort(input int port);
      beat_t t;
      t = '0;
      t.abort = 1'b1;
      srcq[port].push_back(t);
   endtask

   task automatic wait_out(input int n);
      int t;
      t = 0;
      while (outq.size() < n && t < 300) begin
         @(posedge i_clk);
         t++;
      end
      if (outq.size() < n) check("timeout_wait_out", 128'(outq.size()), 128'(n));
   endtask

   task automatic expect_beat(input string tag, input int idx, input beat_t exp);
      beat_t g;
      g = (idx < outq.size()) ? outq[idx] : '1;
      check(tag, 128'(g), 128'(exp));
   endtask

   task automatic expect_abort(input string tag, input int idx);
      beat_t g;
      g = (idx < outq.size()) ? outq[idx] : '0;
      check(tag, 128'({g.abort, g.last}), 128'(2'b10));
   endtask

   task automatic settle_and_count(input string tag, input int n);
      repeat (6) @(posedge i_clk);
      #3;
      check(tag, 128'(outq.size()), 128'(n));
   endtask

   task automatic clear_log();
      outq.delete();
      outcyc.delete();
   endtask

   // Source driver: holds each queued beat until the handshake seen before the edge retires it.
   initial begin
      S_VALID = '0; S_DATA = '0; S_BYTES = '0; S_LAST = '0; S_ABORT = '0; M_READY = 1'b1;
      forever begin
         @(posedge i_clk);
         #1;
         cyc++;
         for (int k = 0; k < NIN; k++) begin
            if (fire[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
            if (srcq[k].size() > 0) begin
               beat_t t;
               t = srcq[k][0];
               S_VALID[k] = 1'b1;
               S_DATA[k*DW +: DW] = t.data;
               S_BYTES[k*WBITS +: WBITS] = t.bytes;
               S_LAST[k] = t.last;
               S_ABORT[k] = t.abort;
            end else begin
               S_VALID[k] = 1'b0;
               S_DATA[k*DW +: DW] = '0;
               S_BYTES[k*WBITS +: WBITS] = '0;
               S_LAST[k] = 1'b0;
               S_ABORT[k] = 1'b0;
            end
         end
         M_READY = toggle_mode ? ~M_READY : 1'b1;
      end
   end

   initial begin
      forever begin
         @(negedge i_clk);
         fire = S_VALID & S_READY;
         if (M_VALID && M_READY) begin
            outq.push_back({M_ABORT, M_LAST, M_BYTES, M_DATA});
            outcyc.push_back(cyc);
         end
         if (o_lenerr != '0) begin
            lenerr_cnt++;
            lenerr_val = o_lenerr;
         end
         if (chk_stable && prev_stall) check("m_data_stable", 128'(M_DATA), 128'(prev_data));
         prev_stall = M_VALID && !M_READY;
         prev_data  = M_DATA;
      end
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      i_reset   = 1'b1;
      i_weights = '0;
      repeat (3) @(posedge i_clk);
      #3;
      check("rst_m_valid", 128'(M_VALID), 128'(0));
      check("rst_m_last",  128'(M_LAST),  128'(0));
      check("rst_m_abort", 128'(M_ABORT), 128'(0));
      check("rst_m_data",  128'(M_DATA),  128'(0));
      check("rst_m_bytes", 128'(M_BYTES), 128'(0));
      check("rst_grant",   128'(o_grant), 128'(0));
      check("rst_lenerr",  128'(o_lenerr), 128'(0));
      i_reset = 1'b0;

      // Four simultaneous 3-beat packets: strict rotation 0..3, contiguous beats, one bubble between.
      @(posedge i_clk); #3;
      for (int k = 0; k < NIN; k++) push_pkt(k, 0, 3);
      wait_out(12);
      settle_and_count("t1_count", 12);
      for (int i = 0; i < 12; i++)
         expect_beat($sformatf("t1_beat%0d", i), i, mk(i / 3, 0, i % 3, (i % 3) == 2));
      if (outcyc.size() >= 12)
         for (int i = 1; i < 12; i++)
            check($sformatf("t1_cyc%0d", i), 128'(outcyc[i] - outcyc[0]), 128'((i / 3) * 4 + i % 3));
      clear_log();

      // Port 1 weight 2: three back-to-back turns, then port 2, then port 1 again.
      i_weights = 16'h0020;
      for (int p = 0; p < 5; p++) push_pkt(1, p, 1);
      push_pkt(2, 0, 1);
      wait_out(6);
      settle_and_count("t2_count", 6);
      expect_beat("t2_o0", 0, mk(1, 0, 0, 1));
      expect_beat("t2_o1", 1, mk(1, 1, 0, 1));
      expect_beat("t2_o2", 2, mk(1, 2, 0, 1));
      expect_beat("t2_o3", 3, mk(2, 0, 0, 1));
      expect_beat("t2_o4", 4, mk(1, 3, 0, 1));
      expect_beat("t2_o5", 5, mk(1, 4, 0, 1));
      i_weights = '0;
      clear_log();

      // Source abort after two forwarded beats, then a normal packet from the same port.
      push_pkt(0, 0, 4);
      void'(srcq[0].pop_back());
      void'(srcq[0].pop_back());
      push_abort(0);
      wait_out(3);
      push_pkt(0, 1, 1);
      wait_out(4);
      settle_and_count("t3_count", 4);
      expect_beat("t3_d0", 0, mk(0, 0, 0, 0));
      expect_beat("t3_d1", 1, mk(0, 0, 1, 0));
      expect_abort("t3_abort", 2);
      expect_beat("t3_next", 3, mk(0, 1, 0, 1));
      clear_log();

      // Backpressure toggling every cycle on a 6-beat packet.
      toggle_mode = 1'b1;
      chk_stable  = 1'b1;
      push_pkt(2, 0, 6);
      wait_out(6);
      toggle_mode = 1'b0;
      chk_stable  = 1'b0;
      settle_and_count("t4_count", 6);
      for (int i = 0; i < 6; i++)
         expect_beat($sformatf("t4_beat%0d", i), i, mk(2, 0, i, i == 5));
      clear_log();

      // 7-beat packet on port 3 against a 4-beat length limit.
      lenerr_cnt = 0;
      lenerr_val = '0;
      push_pkt(3, 0, 7);
`ifdef AXINWARB_MAXLEN_EN
      for (int t = 0; t < 300 && srcq[3].size() > 0; t++) @(posedge i_clk);
      check("t5_drained", 128'(srcq[3].size()), 128'(0));
      settle_and_count("t5_count", 5);
      for (int i = 0; i < 4; i++)
         expect_beat($sformatf("t5_beat%0d", i), i, mk(3, 0, i, 0));
      expect_abort("t5_abort", 4);
      check("t5_lenerr_cnt", 128'(lenerr_cnt), 128'(1));
      check("t5_lenerr_val", 128'(lenerr_val), 128'(4'b1000));
`else
      wait_out(7);
      settle_and_count("t5_count", 7);
      for (int i = 0; i < 7; i++)
         expect_beat($sformatf("t5_beat%0d", i), i, mk(3, 0, i, i == 6));
      check("t5_lenerr_cnt", 128'(lenerr_cnt), 128'(0));
`endif
      clear_log();

      // Reset in the middle of a port-2 packet, then a fresh packet.
      push_pkt(2, 0, 4);
      wait_out(2);
      #3;
      i_reset = 1'b1;
      @(posedge i_clk); #3;
      check("t6_rst_m_valid", 128'(M_VALID), 128'(0));
      check("t6_rst_grant",   128'(o_grant), 128'(0));
      srcq[2].delete();
      @(posedge i_clk); #3;
      i_reset = 1'b0;
      clear_log();
      push_pkt(2, 9, 2);
      wait_out(2);
      settle_and_count("t6_count", 2);
      expect_beat("t6_beat0", 0, mk(2, 9, 0, 0));
      expect_beat("t6_beat1", 1, mk(2, 9, 1, 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
